// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the instruction-fetch / IF-ID pipeline slice.
// Contents:
//   INSTR_W                      instruction word width
//   OP_ANDI/OP_ORI/OP_XORI/OP_LUI opcodes whose immediate is zero-extended
//   state_t                      fetch FSM states (S_BOOT, S_FETCH, S_HOLD)
//   pc_inc()                     32-bit modulo PC increment
package if_id_stage_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Wraps 32'hFFFF_FFFC to 0.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory fetch bus.
//   req    fetch request; addr valid while high   (master -> slave)
//   addr   fetch address                          (master -> slave)
//   ready  rdata valid for addr this cycle        (slave -> master)
//   rdata  fetched instruction word               (slave -> master)
interface if_id_stage_if;
  import if_id_stage_pkg::*;

  logic               req;
  logic [31:0]        addr;
  logic               ready;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/if_id_stage_ext_sel_decode.sv
// ext_sel_decode: maps an instruction opcode to the immediate extend select.
//   opcode      in   6  instr[31:26]
//   ext_signal  out  1  1 = sign-extend, 0 = zero-extend (ANDI/ORI/XORI/LUI)
// Purely combinational.
module ext_sel_decode
  import if_id_stage_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       ext_signal
);

  always_comb begin
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: ext_signal = 1'b0;
      default:                          ext_signal = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: instruction-fetch unit plus IF/ID pipeline register.
// Holds the PC, issues fetches, registers the fetched word with its
// immediate and extend select, absorbs stall back-pressure with a one-entry
// skid buffer and handles branch redirects.
// Ports:
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   imem            fetch bus (master modport of if_id_stage_if)
//   stall           ID cannot accept; hold IF/ID contents
//   redirect        taken branch/jump: flush and refetch from redirect_pc
//   redirect_pc     new fetch address ([1:0] ignored)
//   id_valid        IF/ID holds a live instruction
//   id_pc, id_pc4   address of id_instr and that address + 4
//   id_instr        instruction word
//   id_imm_16       id_instr[15:0]
//   id_ext_signal   1 = sign-extend imm, 0 = zero-extend; 0 while !id_valid
// Build option IF_ID_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
// Parameter RESET_PC: PC loaded on reset.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  if_id_stage_if.master      imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               id_valid,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  output logic [INSTR_W-1:0] id_instr,
  output logic [15:0]        id_imm_16,
  output logic               id_ext_signal
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  state_t             state, state_next;
  logic [31:0]        pc, pc_d;
  logic [31:0]        skid_pc;
  logic [INSTR_W-1:0] skid_instr;

  logic               load_fetch;
  logic               load_skid;
  logic               capture;
  logic               bubble;

  logic [31:0]        src_pc;
  logic [INSTR_W-1:0] src_instr;
  logic               src_ext;

  logic               unused_rpc_bits;
  assign unused_rpc_bits = ^redirect_pc[1:0];

  assign imem.addr = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_next;
  end

  // Next state, PC update and datapath strobes. Redirect overrides
  // everything, including the idle boot cycle.
  always_comb begin
    state_next = state;
    pc_d       = pc;
    imem.req   = 1'b0;
    load_fetch = 1'b0;
    load_skid  = 1'b0;
    capture    = 1'b0;
    bubble     = 1'b0;

    if (state == S_FETCH) imem.req = 1'b1;

    if (redirect) begin
      state_next = S_FETCH;
      pc_d       = {redirect_pc[31:2], 2'b00};
    end else begin
      case (state)
        S_BOOT: state_next = S_FETCH;
        S_FETCH: begin
          if (imem.ready && !stall) begin
            load_fetch = 1'b1;
            pc_d       = pc_inc(pc);
          end else if (imem.ready && stall) begin
            capture    = 1'b1;
            state_next = S_HOLD;
          end else if (!imem.ready && !stall) begin
            bubble     = 1'b1;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load_skid  = 1'b1;
            pc_d       = pc_inc(pc);
            state_next = S_FETCH;
          end
        end
        default: state_next = S_BOOT;
      endcase
    end
  end

  // One decoder serves both the live fetch and the skid drain.
  assign src_pc    = load_skid ? skid_pc    : pc;
  assign src_instr = load_skid ? skid_instr : imem.rdata;

  ext_sel_decode u_ext_sel_decode (
    .opcode     (src_instr[31:26]),
    .ext_signal (src_ext)
  );

  // PC, skid buffer and IF/ID register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      skid_pc       <= '0;
      skid_instr    <= '0;
      id_valid      <= 1'b0;
      id_pc         <= '0;
      id_pc4        <= '0;
      id_instr      <= '0;
      id_ext_signal <= 1'b0;
    end else begin
      pc <= pc_d;
      if (redirect || bubble) begin
        id_valid      <= 1'b0;
        id_ext_signal <= 1'b0;
      end else if (load_fetch || load_skid) begin
        id_valid      <= 1'b1;
        id_pc         <= src_pc;
        id_pc4        <= pc_inc(src_pc);
        id_instr      <= src_instr;
        id_ext_signal <= src_ext;
      end else if (capture) begin
        skid_pc    <= pc;
        skid_instr <= imem.rdata;
      end
    end
  end

  assign id_imm_16 = id_instr[15:0];

`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (load_fetch || load_skid) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall && id_valid)       perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: directed sequences, an opcode/immediate vector
// table and randomized traffic, all checked against a behavioural model.
module tb_if_id_stage;
  import if_id_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_instr;
  logic [15:0] id_imm_16;
  logic        id_ext_signal;
`ifdef IF_ID_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  if_id_stage_if imem_bus ();

  if_id_stage #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem_bus),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_pc4        (id_pc4),
    .id_instr      (id_instr),
    .id_imm_16     (id_imm_16),
    .id_ext_signal (id_ext_signal)
`ifdef IF_ID_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0] m_pc, m_idpc, m_instr, m_skid_pc, m_skid_word;
  bit          m_boot, m_hold, m_valid;
  logic [31:0] m_fcnt, m_scnt;

  typedef struct {
    logic [31:0] word;
    logic [15:0] imm;
    bit          ext;
  } vec_t;

  function automatic bit exp_ext(logic [31:0] w);
    int op;
    op = int'(w[31:26]);
    return !(op >= 12 && op <= 15);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_load(logic [31:0] a, logic [31:0] w);
    m_idpc  = a;
    m_instr = w;
    m_valid = 1'b1;
    m_fcnt  = m_fcnt + 32'd1;
  endtask

  task automatic model_step(bit r, bit rdy, logic [31:0] w, bit st, bit rd, logic [31:0] rpc);
    if (!r) begin
      m_pc = RESET_PC; m_boot = 1'b1; m_hold = 1'b0; m_valid = 1'b0;
      m_idpc = '0; m_instr = '0; m_fcnt = '0; m_scnt = '0;
      return;
    end
    if (st && m_valid) m_scnt = m_scnt + 32'd1;
    if (rd) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_valid = 1'b0; m_hold = 1'b0; m_boot = 1'b0;
      return;
    end
    if (m_boot) begin
      m_boot = 1'b0;
      return;
    end
    if (m_hold) begin
      if (!st) begin
        model_load(m_skid_pc, m_skid_word);
        m_pc = m_pc + 32'd4;
        m_hold = 1'b0;
      end
      return;
    end
    if (rdy && !st) begin
      model_load(m_pc, w);
      m_pc = m_pc + 32'd4;
    end else if (rdy) begin
      m_hold = 1'b1; m_skid_pc = m_pc; m_skid_word = w;
    end else if (!st) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("imem_req", imem_bus.req, !(m_boot || m_hold));
    chk("imem_addr", imem_bus.addr, m_pc);
    chk("id_valid", id_valid, m_valid);
    chk("id_ext_signal", id_ext_signal, m_valid ? exp_ext(m_instr) : 1'b0);
    if (m_valid) begin
      chk("id_pc", id_pc, m_idpc);
      chk("id_pc4", id_pc4, m_idpc + 32'd4);
      chk("id_instr", id_instr, m_instr);
      chk("id_imm_16", id_imm_16, m_instr[15:0]);
    end
`ifdef IF_ID_PERF_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_fcnt);
    chk("perf_stall_cnt", perf_stall_cnt, m_scnt);
`endif
  endtask

  // Called at a negedge: drive, clock, step the model, compare at the next negedge.
  task automatic cyc(bit r, bit rdy, logic [31:0] w, bit st, bit rd, logic [31:0] rpc);
    rst_n = r; imem_bus.ready = rdy; imem_bus.rdata = w;
    stall = st; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    model_step(r, rdy, w, st, rd, rpc);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    vec_t        vecs[8];
    logic [31:0] wa, wb, wc, pc_b;

    vecs[0] = '{32'h2008_FFFF, 16'hFFFF, 1'b1};  // ADDI
    vecs[1] = '{32'h3408_8000, 16'h8000, 1'b0};  // ORI
    vecs[2] = '{32'h3000_1234, 16'h1234, 1'b0};  // ANDI
    vecs[3] = '{32'h3800_00FF, 16'h00FF, 1'b0};  // XORI
    vecs[4] = '{32'h3C01_ABCD, 16'hABCD, 1'b0};  // LUI
    vecs[5] = '{32'h2C00_7FFF, 16'h7FFF, 1'b1};  // SLTIU (0x0B)
    vecs[6] = '{32'h4000_0001, 16'h0001, 1'b1};  // opcode 0x10
    vecs[7] = '{32'h8C22_0010, 16'h0010, 1'b1};  // LW

    rst_n = 1'b0; imem_bus.ready = 1'b0; imem_bus.rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);

    // Reset state.
    cyc(0, 1, 32'h2008_FFFF, 0, 1, 32'h100);
    cyc(0, 1, 32'h2008_FFFF, 0, 0, 0);
    chk("rst_req", imem_bus.req, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_pc4", id_pc4, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_imm", id_imm_16, 0);
    chk("rst_ext", id_ext_signal, 0);

    // Boot cycle then back-to-back ADDI fetches.
    cyc(1, 1, 32'h2008_FFFF, 0, 0, 0);
    chk("boot_first_addr", imem_bus.addr, RESET_PC);
    chk("boot_first_req", imem_bus.req, 1);
    cyc(1, 1, 32'h2008_FFFF, 0, 0, 0);
    chk("f1_id_pc", id_pc, 32'h0);
    chk("f1_imm", id_imm_16, 16'hFFFF);
    chk("f1_ext", id_ext_signal, 1);
    chk("f1_addr", imem_bus.addr, 32'h4);
    cyc(1, 1, 32'h2008_FFFF, 0, 0, 0);
    chk("f2_id_pc", id_pc, 32'h4);
    chk("f2_addr", imem_bus.addr, 32'h8);

    // Opcode / immediate table.
    for (int unsigned i = 0; i < 8; i++) begin
      cyc(1, 1, vecs[i].word, 0, 0, 0);
      chk("tbl_valid", id_valid, 1);
      chk("tbl_instr", id_instr, vecs[i].word);
      chk("tbl_imm", id_imm_16, vecs[i].imm);
      chk("tbl_ext", id_ext_signal, vecs[i].ext);
    end

    // Stall with skid capture: no word lost or duplicated.
    wa = 32'h2001_000A; wb = 32'h2002_000B; wc = 32'h2003_000C;
    cyc(1, 1, wa, 0, 0, 0);
    pc_b = imem_bus.addr;
    cyc(1, 1, wb, 1, 0, 0);
    chk("stall_hold_a", id_instr, wa);
    chk("stall_valid", id_valid, 1);
    chk("stall_req", imem_bus.req, 0);
    cyc(1, 0, 32'h1111_1111, 1, 0, 0);
    cyc(1, 1, 32'h2222_2222, 1, 0, 0);
    chk("stall_still_a", id_instr, wa);
    cyc(1, 1, 32'h3333_3333, 0, 0, 0);
    chk("unstall_b", id_instr, wb);
    chk("unstall_b_pc", id_pc, pc_b);
    cyc(1, 1, wc, 0, 0, 0);
    chk("after_c", id_instr, wc);
    chk("after_c_pc", id_pc, pc_b + 32'd4);

    // Redirect beats stall and ready; low address bits forced to zero.
    cyc(1, 1, wa, 0, 0, 0);
    cyc(1, 1, 32'hDEAD_BEEF, 1, 1, 32'h0000_0043);
    chk("redir_addr", imem_bus.addr, 32'h0000_0040);
    chk("redir_valid", id_valid, 0);
    chk("redir_ext", id_ext_signal, 0);

    // PC wrap.
    cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_addr0", imem_bus.addr, 32'hFFFF_FFFC);
    cyc(1, 1, wa, 0, 0, 0);
    chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_id_pc4", id_pc4, 32'h0);
    chk("wrap_addr1", imem_bus.addr, 32'h0);
    cyc(1, 1, wb, 0, 0, 0);
    chk("wrap_id_pc_b", id_pc, 32'h0);

    // Reset while holding.
    cyc(1, 1, wa, 0, 0, 0);
    cyc(1, 1, wb, 1, 0, 0);
    cyc(0, 1, wc, 1, 0, 0);
    chk("rsthold_valid", id_valid, 0);
    chk("rsthold_instr", id_instr, 0);
    chk("rsthold_req", imem_bus.req, 0);
    cyc(1, 1, wc, 0, 0, 0);
    chk("rsthold_addr", imem_bus.addr, RESET_PC);
    chk("rsthold_req1", imem_bus.req, 1);

    // Randomized traffic.
    for (int unsigned i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, $urandom,
          $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
